// File: rtl/console_writer_if.sv
// Bus between the CPU display-data register and the console writer.
// slave  : console_writer (takes DDR strobes, drives text-buffer writes)
// master : CPU / testbench side
interface console_writer_if;
  logic        ddr_we;
  logic [7:0]  ddr_data;
  logic        dsr_ready;
  logic [3:0]  new_char;
  logic [11:0] waddr;
  logic        text_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        overrun;

  modport slave (
    input  ddr_we, ddr_data,
    output dsr_ready, new_char, waddr, text_en, cursor_col, cursor_row, overrun
  );

  modport master (
    output ddr_we, ddr_data,
    input  dsr_ready, new_char, waddr, text_en, cursor_col, cursor_row, overrun
  );
endinterface

// File: rtl/console_writer.sv
// console_writer: turns DDR byte writes into text-buffer cell writes while
// tracking an 80x30 wrapping cursor and handling CR, LF, BS and FF.
// Optional build macro CONSOLE_CLEAR_ON_RESET_EN: reset enters the CLEAR
// sweep instead of IDLE, so the screen is blanked after every reset.
//
// state | meaning
// IDLE  | ready for a byte (dsr_ready=1)
// BUSY  | one-cycle recovery after a byte
// CLEAR | writing code 0 to every cell, ascending address
module console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic            clk,
  input  logic            rst_n,
  console_writer_if.slave bus
);

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, CLEAR} state_t;

`ifdef CONSOLE_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t      state_q;
  logic        text_en_q;
  logic [11:0] waddr_q;
  logic [3:0]  new_char_q;
  logic [6:0]  col_q;
  logic [4:0]  row_q;
  logic        overrun_q;

  logic [6:0]  bs_col_d;
  logic [4:0]  bs_row_d;

  // row*80 as (row<<6)+(row<<4); shift amounts assume COLS=80
  function automatic logic [11:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
    return {1'b0, r, 6'b0} + {3'b0, r, 4'b0} + {5'b0, c};
  endfunction

  function automatic logic [4:0] next_row(input logic [4:0] r);
    return (r == LAST_ROW) ? 5'd0 : r + 5'd1;
  endfunction

  function automatic logic [3:0] glyph(input logic [7:0] b);
    logic [3:0] g;
    g = 4'd15;
    if (b == 8'h20)                      g = 4'd0;
    else if (b >= 8'h30 && b <= 8'h39)   g = b[3:0] + 4'd1;
    else if (b == 8'h78)                 g = 4'd11;
    else if (b == 8'h3A)                 g = 4'd12;
    else if (b == 8'h2D)                 g = 4'd13;
    else if (b == 8'h2B)                 g = 4'd14;
    return g;
  endfunction

  // backspace target: one cell left, wrapping to the previous row, pinned at (0,0)
  always_comb begin
    bs_col_d = col_q;
    bs_row_d = row_q;
    if (col_q != 7'd0) begin
      bs_col_d = col_q - 7'd1;
    end else if (row_q != 5'd0) begin
      bs_col_d = LAST_COL;
      bs_row_d = row_q - 5'd1;
    end
  end

  // main FSM with registered text-buffer outputs and cursor
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      text_en_q  <= 1'b0;
      waddr_q    <= 12'd0;
      new_char_q <= 4'd0;
      col_q      <= 7'd0;
      row_q      <= 5'd0;
      overrun_q  <= 1'b0;
    end else begin
      text_en_q <= 1'b0;
      if (bus.ddr_we && state_q != IDLE) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (bus.ddr_we) begin
            state_q <= BUSY;
            if (bus.ddr_data == 8'h0C) begin
              state_q    <= CLEAR;
              text_en_q  <= 1'b1;
              waddr_q    <= 12'd0;
              new_char_q <= 4'd0;
              col_q      <= 7'd0;
              row_q      <= 5'd0;
            end else if (bus.ddr_data == 8'h0A) begin
              col_q <= 7'd0;
              row_q <= next_row(row_q);
            end else if (bus.ddr_data == 8'h0D) begin
              col_q <= 7'd0;
            end else if (bus.ddr_data == 8'h08) begin
              col_q      <= bs_col_d;
              row_q      <= bs_row_d;
              text_en_q  <= 1'b1;
              waddr_q    <= cell_addr(bs_row_d, bs_col_d);
              new_char_q <= 4'd0;
            end else if (bus.ddr_data >= 8'h20 && bus.ddr_data <= 8'h7E) begin
              text_en_q  <= 1'b1;
              waddr_q    <= cell_addr(row_q, col_q);
              new_char_q <= glyph(bus.ddr_data);
              if (col_q == LAST_COL) begin
                col_q <= 7'd0;
                row_q <= next_row(row_q);
              end else begin
                col_q <= col_q + 7'd1;
              end
            end
          end
        end
        BUSY: state_q <= IDLE;
        CLEAR: begin
          // text_en low here only right after reset: start the sweep at cell 0
          if (!text_en_q) begin
            text_en_q  <= 1'b1;
            waddr_q    <= 12'd0;
            new_char_q <= 4'd0;
          end else if (waddr_q == LAST_ADDR) begin
            state_q <= IDLE;
          end else begin
            text_en_q <= 1'b1;
            waddr_q   <= waddr_q + 12'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dsr_ready  = (state_q == IDLE);
  assign bus.text_en    = text_en_q;
  assign bus.waddr      = waddr_q;
  assign bus.new_char   = new_char_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_console_writer.sv
// Directed bench for console_writer: printable writes, wrap, CR/LF/BS,
// FF sweep with an overrun strobe, and reset in the middle of a sweep.
module tb_console_writer;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  console_writer_if bus ();

  console_writer #(.COLS(80), .ROWS(30)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // strobe one byte; returns in the cycle after the accepting edge
  task automatic send(input logic [7:0] b);
    bus.ddr_we   = 1'b1;
    bus.ddr_data = b;
    step();
    bus.ddr_we   = 1'b0;
  endtask

  task automatic send_idle(input logic [7:0] b);
    send(b);
    step();
  endtask

  task automatic chk_write(input string tag, input logic [11:0] a, input logic [3:0] g);
    chk({tag, "_en"},    32'(bus.text_en), 32'd1);
    chk({tag, "_addr"},  32'(bus.waddr), 32'(a));
    chk({tag, "_glyph"}, 32'(bus.new_char), 32'(g));
  endtask

  task automatic chk_cur(input string tag, input int c, input int r);
    chk({tag, "_col"}, 32'(bus.cursor_col), 32'(c));
    chk({tag, "_row"}, 32'(bus.cursor_row), 32'(r));
  endtask

  initial begin
    int errs;
    rst_n        = 1'b0;
    bus.ddr_we   = 1'b0;
    bus.ddr_data = 8'h00;
    repeat (3) step();

    chk("rst_text_en", 32'(bus.text_en), 32'd0);
    chk("rst_waddr",   32'(bus.waddr), 32'd0);
    chk("rst_newchar", 32'(bus.new_char), 32'd0);
    chk_cur("rst", 0, 0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
`ifdef CONSOLE_CLEAR_ON_RESET_EN
    chk("rst_dsr", 32'(bus.dsr_ready), 32'd0);
    rst_n = 1'b1;
    step();
    errs = 0;
    for (int i = 0; i < 2400; i++) begin
      if (!(bus.text_en === 1'b1 && bus.waddr === 12'(i) && bus.dsr_ready === 1'b0)) errs++;
      step();
    end
    chk("por_sweep_errs", 32'(errs), 32'd0);
    chk("por_sweep_dsr_up", 32'(bus.dsr_ready), 32'd1);
`else
    chk("rst_dsr", 32'(bus.dsr_ready), 32'd1);
    rst_n = 1'b1;
`endif

    // 'A' at (0,0)
    send(8'h41);
    chk_write("A", 12'd0, 4'd15);
    chk_cur("A", 1, 0);
    chk("A_dsr_low", 32'(bus.dsr_ready), 32'd0);
    step();
    chk("A_dsr_high", 32'(bus.dsr_ready), 32'd1);
    chk("A_en_off", 32'(bus.text_en), 32'd0);

    // walk to (79,29), then '7' wraps to (0,0)
    send_idle(8'h0D);
    repeat (29) send_idle(8'h0A);
    repeat (79) send_idle(8'h20);
    chk_cur("pre7", 79, 29);
    send(8'h37);
    chk_write("seven", 12'd2399, 4'd8);
    chk_cur("seven", 0, 0);
    step();

    // to (3,3) and write '3'
    repeat (3) send_idle(8'h0A);
    send_idle(8'h30);
    send_idle(8'h31);
    send_idle(8'h32);
    send(8'h33);
    chk_write("three", 12'd243, 4'd4);
    step();
    send_idle(8'h34);
    chk_cur("pos53", 5, 3);

    send(8'h0D);
    chk("cr_no_write", 32'(bus.text_en), 32'd0);
    chk_cur("cr", 0, 3);
    step();
    send(8'h0A);
    chk("lf_no_write", 32'(bus.text_en), 32'd0);
    chk_cur("lf", 0, 4);
    step();
    send(8'h08);
    chk_write("bs", 12'd319, 4'd0);
    chk_cur("bs", 79, 3);
    step();

    send(8'h7F);
    chk("del_no_write", 32'(bus.text_en), 32'd0);
    chk("del_dsr_low", 32'(bus.dsr_ready), 32'd0);
    chk_cur("del", 79, 3);
    step();

    send(8'h3A);
    chk_write("colon", 12'd319, 4'd12);
    chk_cur("colon", 0, 4);
    step();
    chk("pre_ff_overrun", 32'(bus.overrun), 32'd0);

    // FF sweep with a dropped strobe in the middle
    send(8'h0C);
    chk_cur("ff", 0, 0);
    errs = 0;
    for (int i = 0; i < 2400; i++) begin
      if (!(bus.text_en === 1'b1 && bus.waddr === 12'(i) &&
            bus.new_char === 4'd0 && bus.dsr_ready === 1'b0)) errs++;
      if (i == 500) begin
        bus.ddr_we   = 1'b1;
        bus.ddr_data = 8'h41;
      end else begin
        bus.ddr_we = 1'b0;
      end
      step();
    end
    chk("ff_sweep_errs", 32'(errs), 32'd0);
    chk("ff_dsr_up", 32'(bus.dsr_ready), 32'd1);
    chk("ff_en_off", 32'(bus.text_en), 32'd0);
    chk("ff_overrun", 32'(bus.overrun), 32'd1);
    chk_cur("ff_end", 0, 0);

    // backspace at origin writes a space in place
    send(8'h08);
    chk_write("bs00", 12'd0, 4'd0);
    chk_cur("bs00", 0, 0);
    step();

    // reset in the middle of a sweep
    send_idle(8'h32);
    send(8'h0C);
    repeat (1000) step();
    chk("mid_addr", 32'(bus.waddr), 32'd1000);
    rst_n = 1'b0;
    step();
    chk("mid_rst_en", 32'(bus.text_en), 32'd0);
    chk_cur("mid_rst", 0, 0);
    chk("mid_rst_overrun", 32'(bus.overrun), 32'd0);
    rst_n = 1'b1;
`ifndef CONSOLE_CLEAR_ON_RESET_EN
    step();
    step();
    chk("no_resume_en", 32'(bus.text_en), 32'd0);
    chk("no_resume_dsr", 32'(bus.dsr_ready), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
